// File: rtl/pw_auth_if.sv
// Password authenticator bus: set/guess request side and status/pulse side.
// The master modport drives requests; the slave modport is the authenticator.
interface pw_auth_if #(
  parameter int WIDTH     = 8,
  parameter int MAX_TRIES = 3
);
  localparam int TW = $clog2(MAX_TRIES + 1);

  logic             set_valid;
  logic [WIDTH-1:0] set_pw;
  logic             guess_valid;
  logic [WIDTH-1:0] guess_pw;
  logic             guess_ready;
  logic             pw_set;
  logic             matched;
  logic             unmatched;
  logic             locked;
  logic [TW-1:0]    tries_left;

  modport master (
    output set_valid, set_pw, guess_valid, guess_pw,
    input  guess_ready, pw_set, matched, unmatched, locked, tries_left
  );

  modport slave (
    input  set_valid, set_pw, guess_valid, guess_pw,
    output guess_ready, pw_set, matched, unmatched, locked, tries_left
  );
endinterface

// File: rtl/pw_auth_fsm.sv
// Clocked password authenticator: stores a password once, checks guesses
// against it, and locks guessing out for LOCK_CYCLES after MAX_TRIES
// consecutive failures.
// Optional macro AUTH_CHANGE_PW_EN: in ARMED, set_valid without guess_valid
// is a password change authorised by the old password on guess_pw.
//
// state  | meaning
// UNSET  | no password stored; waiting for set_valid
// ARMED  | password stored; one guess accepted per cycle
// LOCKED | too many consecutive failures; guesses refused until timer expires
module pw_auth_fsm #(
  parameter int WIDTH       = 8,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic      clk,
  input  logic      rst,
  pw_auth_if.slave  bus
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [TW-1:0] TRIES_MAX  = TW'(MAX_TRIES);
  localparam logic [TW-1:0] TRIES_LAST = TW'(MAX_TRIES - 1);
  localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCK_CYCLES);

  typedef enum logic [1:0] {
    UNSET  = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pw_q, pw_d;
  logic [TW-1:0]    fail_q, fail_d;
  logic [LW-1:0]    lock_q, lock_d;
  logic             pw_set_q, pw_set_d;
  logic             matched_q, matched_d;
  logic             unmatched_q, unmatched_d;
  logic             chg_req;
  logic             attempt;
  logic             pw_eq;

  // A change request only exists when the feature is built in; a concurrent
  // guess always takes priority over it.
`ifdef AUTH_CHANGE_PW_EN
  assign chg_req = bus.set_valid && !bus.guess_valid;
`else
  assign chg_req = 1'b0;
`endif

  assign attempt = bus.guess_valid || chg_req;
  assign pw_eq   = (bus.guess_pw == pw_q);

  // State and datapath registers; reset discards the stored password.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNSET;
      pw_q        <= '0;
      fail_q      <= '0;
      lock_q      <= '0;
      pw_set_q    <= 1'b0;
      matched_q   <= 1'b0;
      unmatched_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pw_q        <= pw_d;
      fail_q      <= fail_d;
      lock_q      <= lock_d;
      pw_set_q    <= pw_set_d;
      matched_q   <= matched_d;
      unmatched_q <= unmatched_d;
    end
  end

  // Next-state, counter and pulse logic.
  always_comb begin
    state_d     = state_q;
    pw_d        = pw_q;
    fail_d      = fail_q;
    lock_d      = lock_q;
    pw_set_d    = pw_set_q;
    matched_d   = 1'b0;
    unmatched_d = 1'b0;
    case (state_q)
      UNSET: begin
        if (bus.set_valid) begin
          pw_d     = bus.set_pw;
          pw_set_d = 1'b1;
          state_d  = ARMED;
        end
      end
      ARMED: begin
        if (attempt) begin
          if (pw_eq) begin
            matched_d = 1'b1;
            fail_d    = '0;
            if (chg_req) pw_d = bus.set_pw;
          end else begin
            unmatched_d = 1'b1;
            if (fail_q >= TRIES_LAST) begin
              // Saturate at MAX_TRIES and start the lockout timer.
              fail_d  = TRIES_MAX;
              lock_d  = LOCK_LOAD;
              state_d = LOCKED;
            end else begin
              fail_d = fail_q + TW'(1);
            end
          end
        end
      end
      LOCKED: begin
        // Expire on the edge that would take the timer from 1 to 0.
        if (lock_q <= LW'(1)) begin
          lock_d  = '0;
          fail_d  = '0;
          state_d = ARMED;
        end else begin
          lock_d = lock_q - LW'(1);
        end
      end
      default: begin
        state_d = UNSET;
      end
    endcase
  end

  assign bus.guess_ready = (state_q == ARMED);
  assign bus.locked      = (state_q == LOCKED);
  assign bus.pw_set      = pw_set_q;
  assign bus.matched     = matched_q;
  assign bus.unmatched   = unmatched_q;
  assign bus.tries_left  = TRIES_MAX - fail_q;
endmodule
